// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I IF stage with credit-limited prefetch FIFO, IF/ID register and redirect flush
module instruction_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   input  logic                  i_redirect,
   input  logic [DATA_WIDTH-1:0] i_redirect_pc,
   output logic                  o_imem_req_valid,
   input  logic                  i_imem_req_ready,
   output logic [DATA_WIDTH-1:0] o_imem_req_addr,
   input  logic                  i_imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_imem_rsp_data,
   output logic [DATA_WIDTH-1:0] o_if_inst,
   output logic [DATA_WIDTH-1:0] o_if_pc,
   output logic                  o_if_valid
);
   localparam int                    AW      = $clog2(FIFO_DEPTH);
   localparam int                    CW      = AW + 1;
   localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);

   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [CW-1:0]         outstanding, discard, fifo_count, live;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] rsp_pc;
   logic                  req_hs, push, pop;

   // request credit, handshake, FIFO control and the pc of the word now returning
   always_comb begin
      o_imem_req_valid = rst_n && !i_redirect && (outstanding + fifo_count < DEPTH_C);
      o_imem_req_addr  = fetch_pc;
      req_hs           = o_imem_req_valid && i_imem_req_ready;
      push             = i_imem_rsp_valid && discard == '0 && !i_redirect;
      pop              = clk_en && !i_redirect && fifo_count != '0;
      live             = outstanding - discard;
      rsp_pc           = fetch_pc - {{(DATA_WIDTH-CW-2){1'b0}}, live, 2'b00};
   end

   // fetch pc, in-flight count and count of stale responses still to be dropped
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         fetch_pc    <= i_redirect ? (i_redirect_pc & ~DATA_WIDTH'(3)) :
                        req_hs     ? fetch_pc + DATA_WIDTH'(4) : fetch_pc;
         outstanding <= outstanding + CW'(req_hs) - CW'(i_imem_rsp_valid);
         discard     <= i_redirect                           ? outstanding - CW'(i_imem_rsp_valid) :
                        (i_imem_rsp_valid && discard != '0)  ? discard - CW'(1) : discard;
      end
   end

   // prefetch FIFO pointers; a redirect empties it
   always_ff @(posedge clk) begin
      if (!rst_n || i_redirect) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   // prefetch FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst[wr_ptr] <= i_imem_rsp_data;
         fifo_pc[wr_ptr]   <= rsp_pc;
      end
   end

   // IF/ID register: load head of FIFO, else a bubble; redirect squashes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_if_inst  <= NOP;
         o_if_pc    <= '0;
         o_if_valid <= 1'b0;
      end else if (i_redirect) begin
         o_if_inst  <= NOP;
         o_if_valid <= 1'b0;
      end else if (clk_en) begin
         o_if_inst  <= pop ? fifo_inst[rd_ptr] : NOP;
         o_if_pc    <= pop ? fifo_pc[rd_ptr] : o_if_pc;
         o_if_valid <= pop;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> fifo_count != DEPTH_C);
endmodule
